// File: rtl/pipe_chain.sv
// Valid/ready register chain with per-stage stall and flush and optional perf counters.
// Define PIPE_PERF_CNT_EN to build the retire/stall/flush counters.
module pipe_chain #(
  parameter int STAGES = 5,
  parameter int WIDTH  = 96
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_ready,
  input  logic [STAGES-1:0]       stall_req,
  input  logic [STAGES-1:0]       flush_req,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [STAGES-1:0]       stage_valid,
  output logic [STAGES*WIDTH-1:0] stage_data,
  output logic [31:0]             retire_cnt,
  output logic [31:0]             stall_cnt,
  output logic [31:0]             flush_cnt
);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] kill;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic              hold_up;
  logic              kill_up;

  // Hold ripples from the output end; kills accumulate toward the input.
  always_comb begin
    hold    = '0;
    kill    = '0;
    hold_up = !out_ready;
    kill_up = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hold[k] = valid_q[k] & (stall_req[k] | hold_up);
      hold_up = hold[k];
      kill_up = kill_up | flush_req[k];
      kill[k] = kill_up;
    end
  end

  always_comb begin
    valid_d    = '0;
    valid_d[0] = hold[0] ? (valid_q[0] & !kill[0])
                         : (in_valid & !kill[0]);
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = hold[k] ? (valid_q[k] & !kill[k])
                           : (valid_q[k-1] & !kill[k-1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      if (!hold[0]) begin
        data_q[0] <= in_data;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (!hold[k]) begin
          data_q[k] <= data_q[k-1];
        end
      end
    end
  end

  assign in_ready    = !hold[0];
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;

  for (genvar g = 0; g < STAGES; g++) begin : g_pack
    assign stage_data[g*WIDTH +: WIDTH] = data_q[g];
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] retire_q;
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= '0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      if (out_valid & out_ready) begin
        retire_q <= retire_q + 32'd1;
      end
      if (in_valid & !in_ready) begin
        stall_q <= stall_q + 32'd1;
      end
      if (|flush_req) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign retire_cnt = retire_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
`else
  assign retire_cnt = '0;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Directed bench for pipe_chain with an in-order scoreboard on the output.
// Expected counter values follow PIPE_PERF_CNT_EN.
module tb_pipe_chain;

  localparam int S = 5;
  localparam int W = 96;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   in_data;
  logic           in_ready;
  logic [S-1:0]   stall_req;
  logic [S-1:0]   flush_req;
  logic           out_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [S-1:0]   stage_valid;
  logic [S*W-1:0] stage_data;
  logic [31:0]    retire_cnt;
  logic [31:0]    stall_cnt;
  logic [31:0]    flush_cnt;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] sb [$];

  pipe_chain #(.STAGES(S), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall_req(stall_req), .flush_req(flush_req),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(int n);
    logic [31:0] v;
    v = n;
    return {v ^ 32'h5A5A_0000, ~v, v};
  endfunction

  function automatic logic [31:0] ec(int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic cnt_chk(string tag, int r, int s, int f);
    chk({tag, "_retire"}, retire_cnt, ec(r));
    chk({tag, "_stall"}, stall_cnt, ec(s));
    chk({tag, "_flush"}, flush_cnt, ec(f));
  endtask

  task automatic slice_chk(string tag, int k, logic [W-1:0] exp);
    chk(tag, stage_data[k*W +: W], exp);
  endtask

  // Bookkeeping just before the edge, then advance to the next negedge.
  task automatic cyc();
    logic [W-1:0] e;
    #1;
    if (in_valid && in_ready) sb.push_back(in_data);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("sb_data", out_data, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_data   = '0;
    stall_req = '0;
    flush_req = '0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain(int n);
    idle();
    repeat (n) cyc();
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic reset_state_chk(string tag);
    chk({tag, "_sv"}, stage_valid, 0);
    chk({tag, "_sd"}, stage_data, 0);
    chk({tag, "_ir"}, in_ready, 1);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_ret"}, retire_cnt, 0);
    chk({tag, "_stl"}, stall_cnt, 0);
    chk({tag, "_fls"}, flush_cnt, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    reset_state_chk("rst");
    rst_n = 1'b1;

    // streaming 1..10
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = pat(i + 1);
      cyc();
      if (i == 3) chk("lat_early", out_valid, 0);
      if (i == 4) chk("lat_data", out_data, pat(1));
      if (i >= 4) chk("stream_ov", out_valid, 1);
    end
    drain(8);
    cnt_chk("stream", 10, 0, 0);

    // backpressure on a full pipe
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = pat(21 + i);
      cyc();
    end
    chk("bp_full", stage_valid, 5'b11111);
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_data   = pat(999 + i);
      out_ready = 1'b0;
      #1;
      chk("bp_in_ready", in_ready, 0);
      cyc();
      chk("bp_sv", stage_valid, 5'b11111);
      for (int k = 0; k < S; k++) slice_chk("bp_frozen", k, pat(25 - k));
    end
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_data   = pat(26 + i);
      out_ready = 1'b1;
      cyc();
    end
    drain(8);
    cnt_chk("bp", 10, 3, 0);

    // bubble collapse
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = pat(40 + i);
      cyc();
    end
    chk("bub_pre", stage_valid, 5'b10101);
    in_valid = 1'b1;
    in_data  = pat(50);
    #1;
    chk("bub_in_ready", in_ready, 1);
    cyc();
    chk("bub_sv", stage_valid, 5'b11011);
    slice_chk("bub_s4", 4, pat(40));
    slice_chk("bub_s3", 3, pat(42));
    slice_chk("bub_s1", 1, pat(44));
    slice_chk("bub_s0", 0, pat(50));
    drain(8);
    cnt_chk("bub", 4, 0, 0);

    // flush at stage 2 with a full held pipe
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = pat(60 + i);
      cyc();
    end
    chk("fl_full", stage_valid, 5'b11111);
    in_valid  = 1'b1;
    in_data   = pat(70);
    flush_req = 5'b00100;
    #1;
    chk("fl_in_ready", in_ready, 0);
    cyc();
    flush_req = '0;
    chk("fl_sv", stage_valid, 5'b11000);
    slice_chk("fl_s4", 4, pat(60));
    slice_chk("fl_s3", 3, pat(61));
    slice_chk("fl_s2_kept", 2, pat(62));
    slice_chk("fl_s0_kept", 0, pat(64));
    cnt_chk("fl_mid", 0, 1, 1);
    sb.delete();
    sb.push_back(pat(60));
    sb.push_back(pat(61));
    drain(8);
    cnt_chk("fl", 2, 1, 1);

    // flush overrides hold; flush at stage 0 kills the accepted input
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = pat(80 + i);
      cyc();
    end
    in_valid  = 1'b1;
    in_data   = pat(90);
    stall_req = 5'b00010;
    flush_req = 5'b01000;
    out_ready = 1'b0;
    #1;
    chk("foh_in_ready", in_ready, 0);
    cyc();
    chk("foh_sv", stage_valid, 5'b10000);
    chk("foh_out", out_data, pat(80));
    stall_req = '0;
    flush_req = 5'b00001;
    in_data   = pat(91);
    #1;
    chk("fin_in_ready", in_ready, 1);
    cyc();
    flush_req = '0;
    chk("fin_sv", stage_valid, 5'b10000);
    cnt_chk("foh_mid", 0, 1, 2);
    sb.delete();
    sb.push_back(pat(80));
    drain(8);
    cnt_chk("foh", 1, 1, 2);

    // asynchronous reset mid-stream, then restart
    do_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = pat(100 + i);
      cyc();
    end
    cnt_chk("mid_pre", 2, 0, 0);
    chk("mid_full", stage_valid, 5'b11111);
    #2;
    rst_n = 1'b0;
    #1;
    reset_state_chk("mid_rst");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = pat(110 + i);
      cyc();
    end
    idle();
    cyc();
    chk("rs_early", out_valid, 0);
    cyc();
    chk("rs_ov", out_valid, 1);
    chk("rs_data", out_data, pat(110));
    drain(8);
    cnt_chk("rs", 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
